// File: rtl/regfile_pkg.sv
// Shared register-file constants: default widths and MIPS register indices.
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

  // MIPS architectural register indices
  localparam int unsigned REG_ZERO  = 0;
  localparam int unsigned REG_RA    = 31;

endpackage : regfile_pkg

// File: rtl/rf_read_port.sv
// One combinational read port: stored value with same-cycle write bypass
// (port 1 has priority over port 0) and busy bypass for a same-cycle clear.
// Ports:
//   rd_addr            read address
//   stored, busy       array value and busy bit at rd_addr (0 for register 0)
//   wr_en0/addr0/data0 write port 0 (ALU writeback)
//   wr_en1/addr1/data1 write port 1 (load writeback, clears busy)
//   rd_data_c          bypassed read data
//   rd_busy_c          busy flag with a same-cycle port-1 clear applied
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              busy,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [DATA_W-1:0] rd_data_c,
  output logic              rd_busy_c
);

  logic hit0;
  logic hit1;
  logic nonzero;

  // Bypass mux; register 0 never bypasses so it always reads zero
  always_comb begin
    rd_data_c = stored;
    rd_busy_c = busy;
    nonzero   = (rd_addr != ADDR_W'(REG_ZERO));
    hit0      = wr_en0 && (wr_addr0 == rd_addr);
    hit1      = wr_en1 && (wr_addr1 == rd_addr);
    if (nonzero && hit1) begin
      rd_data_c = wr_data1;
    end else if (nonzero && hit0) begin
      rd_data_c = wr_data0;
    end
    if (hit1) begin
      rd_busy_c = 1'b0;
    end
  end

endmodule : rf_read_port

// File: rtl/regfile_scoreboard.sv
// Two-read / two-write register file with a per-register busy scoreboard
// tracking outstanding loads, plus a registered count of busy registers.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rd_addr_a/b              read port addresses
//   rd_data_a/b              read data (combinational, write-bypassed)
//   rd_busy_a/b              addressed register has a pending load
//   wr_en0/addr0/data0       write port 0 (ALU writeback)
//   wr_en1/addr1/data1       write port 1 (load writeback, clears busy)
//   claim_en, claim_addr     mark a register busy (load issued)
//   flush                    clear every busy bit
//   busy_cnt                 number of busy registers
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int unsigned NREG  = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  // Register 0 is hardwired to zero, so only entries 1..NREG-1 are stored
  logic [DATA_W-1:0] regs [NREG-1:1];
  logic [NREG-1:1]   busy_q;
  logic [NREG-1:0]   busy_vec;
  logic [DATA_W-1:0] stored_a;
  logic [DATA_W-1:0] stored_b;
  logic              claim_ok;
  logic              clear_ok;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_next;

  // Stored values and busy bits as seen by the read ports
  always_comb begin
    busy_vec = {busy_q, 1'b0};
    stored_a = '0;
    stored_b = '0;
    if (rd_addr_a != ADDR_W'(REG_ZERO)) stored_a = regs[rd_addr_a];
    if (rd_addr_b != ADDR_W'(REG_ZERO)) stored_b = regs[rd_addr_b];
  end

  // Incremental count update; a claim of the register being cleared keeps it busy
  always_comb begin
    claim_ok = claim_en && (claim_addr != ADDR_W'(REG_ZERO));
    clear_ok = wr_en1 && (wr_addr1 != ADDR_W'(REG_ZERO));
    cnt_inc  = claim_ok && !busy_vec[claim_addr];
    cnt_dec  = clear_ok && busy_vec[wr_addr1] &&
               !(claim_ok && (claim_addr == wr_addr1));
    cnt_next = busy_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  // Data storage; port 1 wins on a same-address double write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 1; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (wr_en1 && (wr_addr1 == ADDR_W'(r))) begin
          regs[r] <= wr_data1;
        end else if (wr_en0 && (wr_addr0 == ADDR_W'(r))) begin
          regs[r] <= wr_data0;
        end
      end
    end
  end

  // Busy scoreboard: flush beats claim, claim beats port-1 clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (flush) begin
          busy_q[r] <= 1'b0;
        end else if (claim_en && (claim_addr == ADDR_W'(r))) begin
          busy_q[r] <= 1'b1;
        end else if (wr_en1 && (wr_addr1 == ADDR_W'(r))) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= '0;
    end else if (flush) begin
      busy_cnt <= '0;
    end else begin
      busy_cnt <= cnt_next;
    end
  end

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_a (
    .rd_addr   (rd_addr_a),
    .stored    (stored_a),
    .busy      (busy_vec[rd_addr_a]),
    .wr_en0    (wr_en0),
    .wr_addr0  (wr_addr0),
    .wr_data0  (wr_data0),
    .wr_en1    (wr_en1),
    .wr_addr1  (wr_addr1),
    .wr_data1  (wr_data1),
    .rd_data_c (rd_data_a),
    .rd_busy_c (rd_busy_a)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_b (
    .rd_addr   (rd_addr_b),
    .stored    (stored_b),
    .busy      (busy_vec[rd_addr_b]),
    .wr_en0    (wr_en0),
    .wr_addr0  (wr_addr0),
    .wr_data0  (wr_data0),
    .wr_en1    (wr_en1),
    .wr_addr1  (wr_addr1),
    .wr_data1  (wr_data1),
    .rd_data_c (rd_data_b),
    .rd_busy_c (rd_busy_b)
  );

endmodule : regfile_scoreboard
